// File: rtl/vga_text_render_if.sv
// Read ports between the VGA text renderer and its text buffer / font ROM.
// Both memories register their data on a clock edge where the read enable is high.
interface vga_text_render_if;
    logic [11:0] text_addr;
    logic        text_re;
    logic [15:0] text_data;
    logic [11:0] font_addr;
    logic        font_re;
    logic [7:0]  font_data;

    modport master (
        output text_addr, text_re, font_addr, font_re,
        input  text_data, font_data
    );
    modport slave (
        input  text_addr, text_re, font_addr, font_re,
        output text_data, font_data
    );
endinterface

// File: rtl/vga_text_render.sv
// Text-mode renderer: rebuilds beam position from raw syncs, fetches char/attr and glyph rows,
// and emits 12-bit CGA colour with the syncs delayed to line up with the pixel.
module vga_text_render #(
    parameter int H_BP  = 48,
    parameter int H_ACT = 640,
    parameter int V_BP  = 33,
    parameter int V_ACT = 480
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              hsync,
    input  logic              vsync,
    vga_text_render_if.master mem,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [11:0]       rgb
);
    localparam logic [9:0]  H_FIRST = 10'(H_BP);
    localparam logic [9:0]  H_END   = 10'(H_BP + H_ACT);
    localparam logic [9:0]  V_FIRST = 10'(V_BP);
    localparam logic [9:0]  V_END   = 10'(V_BP + V_ACT);
    localparam logic [11:0] COLS    = 12'(H_ACT / 8);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [11:0] pal(input logic [3:0] idx);
        logic [11:0] c;
        case (idx)
            4'd0:    c = 12'h000;
            4'd1:    c = 12'h00A;
            4'd2:    c = 12'h0A0;
            4'd3:    c = 12'h0AA;
            4'd4:    c = 12'hA00;
            4'd5:    c = 12'hA0A;
            4'd6:    c = 12'hA50;
            4'd7:    c = 12'hAAA;
            4'd8:    c = 12'h555;
            4'd9:    c = 12'h55F;
            4'd10:   c = 12'h5F5;
            4'd11:   c = 12'h5FF;
            4'd12:   c = 12'hF55;
            4'd13:   c = 12'hF5F;
            4'd14:   c = 12'hFF5;
            default: c = 12'hFFF;
        endcase
        return c;
    endfunction

    logic       hsync_q, vsync_q;
    logic       hrise, vrise;
    logic [9:0] hpos_p0, vpos_p0;
    logic [9:0] x_p0, y_p0;
    logic       vis_p0;
    logic       vld_p1, vld_p2;
    logic [2:0] xoff_p1, xoff_p2;
    logic [3:0] yoff_p1;
    logic [3:0] fg_p2, bg_p2;
    logic       pix_p2;
    logic [3:0] hs_dly, vs_dly;

    always_comb begin
        hrise  = hsync & ~hsync_q;
        vrise  = vsync & ~vsync_q;
        x_p0   = hpos_p0 - H_FIRST;
        y_p0   = vpos_p0 - V_FIRST;
        vis_p0 = (hpos_p0 >= H_FIRST) && (hpos_p0 < H_END) &&
                 (vpos_p0 >= V_FIRST) && (vpos_p0 < V_END);
    end

    // Memory reads are gated by en so the memories advance in step with the pipeline.
    assign mem.text_re   = en & resetn;
    assign mem.font_re   = en & resetn;
    assign mem.text_addr = 12'(y_p0[9:4]) * COLS + 12'(x_p0[9:3]);
    assign mem.font_addr = {mem.text_data[7:0], yoff_p1};
    // Glyph bit 7 is the leftmost pixel, so the bit index is the inverted x offset.
    assign pix_p2        = mem.font_data[~xoff_p2];
    assign hsync_o       = hs_dly[3];
    assign vsync_o       = vs_dly[3];

    // Stage 0: sync history, beam position and the sync delay line
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            hpos_p0 <= '0;
            vpos_p0 <= '0;
            hs_dly  <= 4'hF;
            vs_dly  <= 4'hF;
        end else if (en) begin
            hsync_q <= hsync;
            vsync_q <= vsync;
            hpos_p0 <= hrise ? 10'd0 : sat_inc(hpos_p0);
            if (hrise) begin
                vpos_p0 <= vrise ? 10'd0 : sat_inc(vpos_p0);
            end
            hs_dly  <= {hs_dly[2:0], hsync};
            vs_dly  <= {vs_dly[2:0], vsync};
        end
    end

    // Stage 1: text buffer read in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1  <= 1'b0;
            xoff_p1 <= '0;
            yoff_p1 <= '0;
        end else if (en) begin
            vld_p1  <= vis_p0;
            xoff_p1 <= x_p0[2:0];
            yoff_p1 <= y_p0[3:0];
        end
    end

    // Stage 2: font ROM read in flight, attribute captured
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p2  <= 1'b0;
            xoff_p2 <= '0;
            fg_p2   <= '0;
            bg_p2   <= '0;
        end else if (en) begin
            vld_p2  <= vld_p1;
            xoff_p2 <= xoff_p1;
            fg_p2   <= mem.text_data[11:8];
            bg_p2   <= mem.text_data[15:12];
        end
    end

    // Stage 3: colour out
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rgb <= '0;
        end else if (en) begin
            rgb <= vld_p2 ? pal(pix_p2 ? fg_p2 : bg_p2) : 12'h000;
        end
    end
endmodule
